// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use detect, halt FSM and bubble counter
//
// Purpose:
//   Registers the decoded instruction for the execute stage. It also handles
//   these cases:
//     - flush: a branch or jump redirect kills the stage contents.
//     - stall: a downstream stall holds every register unchanged.
//     - load-use: a hazard inserts a bubble into the execute stage.
//   An instruction with the Halt bit set moves the stage into HALTED once it
//   is actually captured. HALTED is left only through rst.
//
// Configuration:
//   ID_EX_BUBBLE_CNT_EN - when defined, bubble_cnt counts bubbles written in
//                         RUN and saturates at 16'hFFFF. When undefined,
//                         bubble_cnt is tied to 0.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   id_valid             decode stage holds a real instruction
//   id_pc                PC of the decoded instruction
//   id_controls          {Halt, MemRead, MemWrite, ToReg[1:0], ALUOP[1:0],
//                         ALUSrc1, ALUSrc2, RegWrite}
//   id_rs1_data,
//   id_rs2_data, id_imm  register-file operands and immediate
//   id_rs1, id_rs2, id_rd source and destination register numbers
//   id_func              {instruction[30], funct3}
//   stall, flush         downstream hold and redirect kill
//   ex_*                 registered copies of the id_* fields
//   load_use_hazard      combinational load-use detect, drives the IF/ID hold
//   halted               registered halt indication
//   bubble_cnt           inserted-bubble count

module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [9:0]  id_controls,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [3:0]  id_func,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [9:0]  ex_controls,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [3:0]  ex_func,
  output logic        load_use_hazard,
  output logic        halted,
  output logic [15:0] bubble_cnt
);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        halted_q, halted_d;

  logic        ex_valid_q, ex_valid_d;
  logic [31:0] ex_pc_q, ex_pc_d;
  logic [9:0]  ex_controls_q, ex_controls_d;
  logic [31:0] ex_rs1_data_q, ex_rs1_data_d;
  logic [31:0] ex_rs2_data_q, ex_rs2_data_d;
  logic [31:0] ex_imm_q, ex_imm_d;
  logic [4:0]  ex_rs1_q, ex_rs1_d;
  logic [4:0]  ex_rs2_q, ex_rs2_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic [3:0]  ex_func_q, ex_func_d;

  logic        hazard;
  logic        write_bubble;
  logic        do_load;

  // A load sitting in EX cannot forward its data to the instruction in ID
  // in time. Writes to x0 never create a dependency.
  assign hazard = ex_valid_q & ex_controls_q[8] & (ex_rd_q != 5'd0) & id_valid &
                  ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));

  // Next-state selection: flush > stall > load-use > load while running.
  always_comb begin
    state_d      = state_q;
    write_bubble = 1'b0;
    do_load      = 1'b0;

    case (state_q)
      S_RUN: begin
        if (flush) begin
          write_bubble = 1'b1;
        end else if (stall) begin
          write_bubble = 1'b0;
        end else if (hazard) begin
          write_bubble = 1'b1;
        end else begin
          do_load = 1'b1;
          // Only a halt that is really captured stops the machine. A halt
          // that is flushed, stalled or bubbled is discarded.
          if (id_valid && id_controls[9]) begin
            state_d = S_HALTED;
          end
        end
      end
      S_HALTED: begin
        write_bubble = 1'b1;
      end
      default: begin
        state_d      = S_RUN;
        write_bubble = 1'b1;
      end
    endcase

    halted_d = (state_d == S_HALTED);
  end

  // Datapath next-state. When neither a bubble nor a load is selected, the
  // registers keep their values.
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_controls_d = ex_controls_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_imm_d      = ex_imm_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_rd_d       = ex_rd_q;
    ex_func_d     = ex_func_q;

    if (write_bubble) begin
      ex_valid_d    = 1'b0;
      ex_pc_d       = 32'd0;
      ex_controls_d = 10'd0;
      ex_rs1_data_d = 32'd0;
      ex_rs2_data_d = 32'd0;
      ex_imm_d      = 32'd0;
      ex_rs1_d      = 5'd0;
      ex_rs2_d      = 5'd0;
      ex_rd_d       = 5'd0;
      ex_func_d     = 4'd0;
    end else if (do_load) begin
      ex_valid_d    = id_valid;
      ex_pc_d       = id_pc;
      // An invalid slot must not carry side-effecting controls downstream.
      ex_controls_d = id_valid ? id_controls : 10'd0;
      ex_rs1_data_d = id_rs1_data;
      ex_rs2_data_d = id_rs2_data;
      ex_imm_d      = id_imm;
      ex_rs1_d      = id_rs1;
      ex_rs2_d      = id_rs2;
      ex_rd_d       = id_rd;
      ex_func_d     = id_func;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RUN;
      halted_q      <= 1'b0;
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= 32'd0;
      ex_controls_q <= 10'd0;
      ex_rs1_data_q <= 32'd0;
      ex_rs2_data_q <= 32'd0;
      ex_imm_q      <= 32'd0;
      ex_rs1_q      <= 5'd0;
      ex_rs2_q      <= 5'd0;
      ex_rd_q       <= 5'd0;
      ex_func_q     <= 4'd0;
    end else begin
      state_q       <= state_d;
      halted_q      <= halted_d;
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_controls_q <= ex_controls_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_func_q     <= ex_func_d;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  // Count only bubbles that replace real pipeline slots while running. A
  // flush and a load-use hazard in the same cycle still produce one bubble.
  logic        count_en;
  logic [15:0] bubble_cnt_q;

  assign count_en = write_bubble & (state_q == S_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= 16'd0;
    end else if (count_en && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  assign bubble_cnt = 16'd0;
`endif

  assign load_use_hazard = hazard;
  assign halted          = halted_q;
  assign ex_valid        = ex_valid_q;
  assign ex_pc           = ex_pc_q;
  assign ex_controls     = ex_controls_q;
  assign ex_rs1_data     = ex_rs1_data_q;
  assign ex_rs2_data     = ex_rs2_data_q;
  assign ex_imm          = ex_imm_q;
  assign ex_rs1          = ex_rs1_q;
  assign ex_rs2          = ex_rs2_q;
  assign ex_rd           = ex_rd_q;
  assign ex_func         = ex_func_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  input  1  single clock, all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 id_valid  input  1  decode stage holds a real instruction.
REQ-004 id_pc  input  32  PC of decoded instruction.
REQ-005 id_controls  input  10  control word: [9] Halt, [8] MemRead, [7] MemWrite, [6:5] ToReg, [4:3] ALUOP, [2] ALUSrc1, [1] ALUSrc2, [0] RegWrite.
REQ-006 id_rs1_data, id_rs2_data, id_imm  input  32 each  register-file operands and immediate.
REQ-007 id_rs1, id_rs2, id_rd  input  5 each  source/destination register numbers.
REQ-008 id_func  input  4  {instruction[30], funct3}.
REQ-009 stall  input  1  downstream stall; hold register contents.
REQ-010 flush  input  1  branch/jump redirect; kill stage contents.
REQ-011 ex_valid, ex_pc, ex_controls, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_func  output  widths as inputs  registered copies for execute stage.
REQ-012 load_use_hazard  output  1  combinational load-use detect; drives IF/ID hold.
REQ-013 halted  output  1  processor halted by ECALL-class Halt bit.
REQ-014 bubble_cnt  output  16  inserted-bubble count (see Configuration).

Function
REQ-015 load_use_hazard SHALL = ex_valid & ex_controls[8] & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
REQ-016 State machine SHALL have two states: RUN, HALTED.
REQ-017 In RUN, per-edge update priority SHALL be: flush > stall > load_use_hazard > load.
REQ-018 flush SHALL write a bubble: ex_valid=0, ex_controls=0, all data/register fields 0.
REQ-019 stall (no flush) SHALL hold every output register unchanged.
REQ-020 load_use_hazard (no flush, no stall) SHALL write a bubble as REQ-018.
REQ-021 load SHALL copy all id_* fields; if id_valid=0, ex_controls SHALL be forced to 0.
REQ-022 RUN -> HALTED SHALL occur on an edge that performs a load with id_valid=1 and id_controls[9]=1; that instruction SHALL be captured with ex_controls[9]=1 for one cycle.
REQ-023 In HALTED, each edge SHALL write a bubble regardless of stall/flush/id inputs; halted=1; exit only via rst.
REQ-024 A halt instruction that is flushed, stalled or bubbled SHALL NOT cause the transition.
REQ-025 halted SHALL be a registered output asserted the cycle after the transition edge.
REQ-026 Latency id_* -> ex_* SHALL be exactly one clock.
REQ-027 Simultaneous flush and load_use_hazard SHALL produce one bubble (counted once).

Reset
REQ-028 rst SHALL immediately, without clock, force state=RUN, halted=0, ex_valid=0, all ex_* fields=0, bubble_cnt=0.
REQ-029 rst asserted mid-halt or mid-stall SHALL fully clear state; first post-reset edge SHALL obey REQ-017.

Configuration
REQ-030 Macro ID_EX_BUBBLE_CNT_EN defined: bubble_cnt SHALL increment by 1 on every edge in RUN that writes a bubble per REQ-018/REQ-020, saturating at 16'hFFFF; no increment in HALTED or on stall.
REQ-031 Macro undefined: bubble_cnt SHALL be constant 0 and no counter logic synthesized; all other behaviour identical.

Verification
REQ-032 Load: id_valid=1, id_pc=0x100, id_controls=10'b0_0_0_01_10_0_0_1, id_rd=5, no stall/flush -> next cycle ex_pc=0x100, ex_controls matches, ex_rd=5, ex_valid=1.
REQ-033 Load-use: ex holds load (controls 10'b0_1_0_10_00_0_1_1, ex_rd=7), id_rs2=7 -> load_use_hazard=1 same cycle, next cycle ex_valid=0, ex_controls=0, bubble_cnt=1 (macro on).
REQ-034 Load-use with ex_rd=0 and id_rs1=0 -> load_use_hazard=0, instruction loaded normally.
REQ-035 stall=1 and flush=1 together over a valid ex entry -> bubble written; stall=1 alone for 3 cycles -> ex_* unchanged, bubble_cnt unchanged.
REQ-036 Halt: id_controls=10'b1_0_0_00_00_0_0_0, id_valid=1 -> next cycle ex_controls[9]=1, halted=1; following cycles ex_valid=0 despite new id inputs; same stimulus with flush=1 -> halted stays 0.
REQ-037 Assert rst asynchronously between edges while halted=1 -> halted, ex_valid, bubble_cnt drop to 0 before next edge.
